// File: rtl/data_mem_responder.sv
// Multi-cycle word memory responder: stalls the requester for the access latency, then pulses Done.
// Optional MEM_RAND_LATENCY_EN adds 0..3 pseudo-random extra BUSY cycles per access.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        Halt,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, HALTED} state_t;

  localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       dout_q, dout_d;
  logic              is_wr_q, is_wr_d;
  logic              err_q, err_d;
  logic              halt_pend_q, halt_pend_d;
  logic [15:0]       mem [2**ADDR_W];

  logic       req_legal, req_illegal, accept;
  logic [4:0] load_val;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^Addr[15:ADDR_W+1];
  assign req_legal      = (Rd ^ Wr) & ~Addr[0];
  assign req_illegal    = (Rd & Wr) | ((Rd ^ Wr) & Addr[0]);
  assign accept         = (state_q == IDLE) & ~Halt & req_legal;

`ifdef MEM_RAND_LATENCY_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR x^8+x^6+x^5+x^4; extra latency uses the value before stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lfsr_q <= 8'hA5;
    else if (accept) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign load_val = LAT_M1 + {3'b000, lfsr_q[1:0]};
`else
  assign load_val = LAT_M1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    dout_d      = dout_q;
    halt_pend_d = halt_pend_q;
    err_d       = 1'b0;
    Stall       = 1'b0;
    Done        = 1'b0;
    DataOut     = dout_q;
    case (state_q)
      IDLE: begin
        if (Halt) begin
          state_d = HALTED;
        end else if (req_legal) begin
          Stall   = 1'b1;
          addr_d  = Addr[ADDR_W:1];
          wdata_d = DataIn;
          is_wr_d = Wr;
          cnt_d   = load_val;
          state_d = (load_val == 5'd0) ? RESP : BUSY;
        end else if (req_illegal) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = RESP;
        if (Halt) halt_pend_d = 1'b1;
      end
      RESP: begin
        Done = 1'b1;
        // Read data is presented combinationally in the Done cycle, then held in dout_q.
        if (!is_wr_q) begin
          DataOut = mem[addr_q];
          dout_d  = mem[addr_q];
        end
        halt_pend_d = 1'b0;
        state_d     = (halt_pend_q | Halt) ? HALTED : IDLE;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      is_wr_q     <= 1'b0;
      dout_q      <= 16'h0000;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // The array is not reset; a write only lands at the end of its Done cycle.
  always_ff @(posedge clk) begin
    if (state_q == RESP && is_wr_q) mem[addr_q] <= wdata_q;
  end

  assign Err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: drivers push expected Done/Err events, a monitor pops and compares.
module tb_data_mem_responder;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn;
  logic        Rd, Wr, Halt;
  logic [15:0] DataOut;
  logic        Stall, Done, Err;

  data_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr), .Halt(Halt),
    .DataOut(DataOut), .Stall(Stall), .Done(Done), .Err(Err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          err_cyc_q[$];
  logic [15:0] mdl[int];
  logic [15:0] dout_mdl;
  logic [7:0]  ref_lfsr;
  bit          halted_mdl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int next_lat();
`ifdef MEM_RAND_LATENCY_EN
    int l;
    l = LAT + int'(ref_lfsr[1:0]);
    ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    return l;
`else
    return LAT;
`endif
  endfunction

  // Monitor
  always @(negedge clk) begin : monitor
    logic [15:0] d;
    int c;
    if (Done) begin
      done_cnt++;
      chk("done_no_err", {31'd0, Err}, 32'd0);
      chk("done_no_stall", {31'd0, Stall}, 32'd0);
      chk("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("done_cycle", cyc, c);
        chk("done_data", {16'd0, DataOut}, {16'd0, d});
      end
    end
    if (Err) begin
      chk("err_no_stall", {31'd0, Stall}, 32'd0);
      chk("err_expected", {31'd0, err_cyc_q.size() > 0}, 32'd1);
      if (err_cyc_q.size() > 0) chk("err_cycle", cyc, err_cyc_q.pop_front());
    end
  end

  // Drivers
  task automatic wait_idle();
    int k = 0;
    @(posedge clk);
    while ((exp_q.size() != 0 || err_cyc_q.size() != 0) && k < 60) begin
      @(posedge clk);
      k++;
    end
    chk("drain_in_time", {31'd0, (exp_q.size() == 0 && err_cyc_q.size() == 0)}, 32'd1);
    exp_q.delete();
    exp_cyc_q.delete();
    err_cyc_q.delete();
  endtask

  task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] data, input bit scramble);
    bit legal;
    int c;
    int l;
    wait_idle();
    #1;
    Rd = rd; Wr = wr; Addr = addr; DataIn = data;
    c = cyc;
    legal = (rd ^ wr) && !addr[0];
    #1;
    chk("stall_on_req", {31'd0, Stall}, {31'd0, legal && !halted_mdl});
    if (!halted_mdl) begin
      if (legal) begin
        l = next_lat();
        if (rd) dout_mdl = mdl[int'(addr)];
        else    mdl[int'(addr)] = data;
        exp_q.push_back(dout_mdl);
        exp_cyc_q.push_back(c + l);
      end else begin
        err_cyc_q.push_back(c + 1);
      end
    end
    @(posedge clk); #1;
    if (scramble) begin
      Addr = 16'h0030; DataIn = 16'hFFFF; Rd = 1'b0; Wr = 1'b1;
      @(posedge clk); #1;
    end
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_lfsr   = 8'hA5;
    dout_mdl   = 16'h0000;
    halted_mdl = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Halt = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
    ref_lfsr = 8'hA5; dout_mdl = 16'h0000; halted_mdl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dataout", {16'd0, DataOut}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_err", {31'd0, Err}, 32'd0);
    rst = 1'b0;

    // Write then read
    req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

    // Illegal requests leave the array untouched
    req(1'b0, 1'b1, 16'h0002, 16'h0202, 1'b0);
    req(1'b1, 1'b1, 16'h0002, 16'hAAAA, 1'b0);
    req(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
    req(1'b0, 1'b1, 16'h0003, 16'hDEAD, 1'b0);
    req(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);

    // Inputs ignored while BUSY
    req(1'b0, 1'b1, 16'h0020, 16'h5A5A, 1'b0);
    req(1'b0, 1'b1, 16'h0030, 16'h3333, 1'b0);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1);
    req(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);

    // Sweep: 8 writes, 8 read-backs, plus an overwrite
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 16'h0080 + 16'(i * 2), 16'hA000 | 16'(i * 16'h0111), 1'b0);
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 16'h0080 + 16'(i * 2), 16'h0000, 1'b0);
    req(1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

    // Reset mid-operation discards the pending write
    req(1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0);
    req(1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dataout", {16'd0, DataOut}, 32'd0);
    chk("midrst_stall", {31'd0, Stall}, 32'd0);
    chk("midrst_done", {31'd0, Done}, 32'd0);
    chk("midrst_err", {31'd0, Err}, 32'd0);
    exp_q.delete(); exp_cyc_q.delete(); err_cyc_q.delete();
    mdl[16'h0040] = 16'h0000;
    do_reset();
    req(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    req(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);

    // Halt during a BUSY read: access completes, then terminal
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    Halt = 1'b1;
    @(posedge clk); #1;
    Halt = 1'b0;
    halted_mdl = 1'b1;
    wait_idle();
    d0 = done_cnt;
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    req(1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("halted_no_done", done_cnt, d0);
    chk("halted_dataout_held", {16'd0, DataOut}, {16'd0, dout_mdl});

    // Reset exits HALTED; memory retained
    do_reset();
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    req(1'b0, 1'b1, 16'h0002, 16'h7777, 1'b0);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("final_dataout_held", {16'd0, DataOut}, {16'd0, dout_mdl});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
